// File: rtl/complex_accumulator_array_parallel_pkg.sv
// complex_accumulator_array_parallel_pkg
//   Shared types and constants for the 4x4x4 complex accumulator array.
//   - CPLX_DATA_WIDTH : bits per real / imaginary component (signed)
//   - DIM_I/J/K       : lane array dimensions
//   - complex_t       : packed {re, im}, 2*CPLX_DATA_WIDTH bits
//   - lane_array_t    : full per-lane bundle [0:3][0:3][0:3] of complex_t
//   The real component is named "re" because "real" is a reserved word.
package complex_accumulator_array_parallel_pkg;

  localparam int CPLX_DATA_WIDTH = 32;
  localparam int DIM_I = 4;
  localparam int DIM_J = 4;
  localparam int DIM_K = 4;

  typedef struct packed {
    logic signed [CPLX_DATA_WIDTH-1:0] re;
    logic signed [CPLX_DATA_WIDTH-1:0] im;
  } complex_t;

  typedef complex_t [0:DIM_I-1][0:DIM_J-1][0:DIM_K-1] lane_array_t;

endpackage

// File: rtl/complex_accumulator_array_parallel_if.sv
// complex_accumulator_array_parallel_if
//   Burst/result bundle between the multiplier array, the accumulator
//   array and the IFFT stage.
//   - in           : per-lane addend
//   - start / stop : burst delimiters
//   - out          : per-lane accumulated result (held between results)
//   - output_valid : one-cycle pulse on each new result
//   Modports: master = producer/consumer side, slave = accumulator array.
interface complex_accumulator_array_parallel_if;
  import complex_accumulator_array_parallel_pkg::*;

  lane_array_t in;
  logic        start;
  logic        stop;
  lane_array_t out;
  logic        output_valid;

  modport master (
    output in,
    output start,
    output stop,
    input  out,
    input  output_valid
  );

  modport slave (
    input  in,
    input  start,
    input  stop,
    output out,
    output output_valid
  );

endinterface

// File: rtl/complex_accumulator_array_parallel_accumulator.sv
// complex_accumulator
//   One accumulator lane: acc register, component adder and out register.
//   Control decoding is done once in the top; the lane only obeys strobes.
//   Ports:
//   - clk, reset_n : clock, synchronous active-low reset
//   - in_i         : addend for this lane
//   - load_i       : acc <= in (burst start / restart)
//   - add_i        : acc <= acc + in (burst body)
//   - finish_i     : out <= acc + in (last addend of a multi-cycle burst)
//   - single_i     : out <= in (single-element burst)
//   - out_o        : held result
//   Build option: CPLX_ACC_SATURATE_EN makes each component add clamp
//   instead of wrapping.
module complex_accumulator
  import complex_accumulator_array_parallel_pkg::*;
#(
  parameter int DATA_WIDTH = CPLX_DATA_WIDTH
) (
  input  logic     clk,
  input  logic     reset_n,
  input  complex_t in_i,
  input  logic     load_i,
  input  logic     add_i,
  input  logic     finish_i,
  input  logic     single_i,
  output complex_t out_o
);

  function automatic logic signed [DATA_WIDTH-1:0] add_comp(
    input logic signed [DATA_WIDTH-1:0] a,
    input logic signed [DATA_WIDTH-1:0] b
  );
`ifdef CPLX_ACC_SATURATE_EN
    logic signed [DATA_WIDTH:0] wide;
    wide = {a[DATA_WIDTH-1], a} + {b[DATA_WIDTH-1], b};
    // Top two bits disagree only when the true sum left the signed range.
    if (wide[DATA_WIDTH] != wide[DATA_WIDTH-1]) begin
      return wide[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                              : {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end
    return wide[DATA_WIDTH-1:0];
`else
    return a + b;
`endif
  endfunction

  complex_t acc_q, acc_d;
  complex_t out_q, out_d;
  complex_t sum;

  always_comb begin
    sum.re = add_comp(acc_q.re, in_i.re);
    sum.im = add_comp(acc_q.im, in_i.im);

    acc_d = acc_q;
    if (load_i) begin
      acc_d = in_i;
    end else if (add_i) begin
      acc_d = sum;
    end

    out_d = out_q;
    if (single_i) begin
      out_d = in_i;
    end else if (finish_i) begin
      out_d = sum;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      acc_q <= '0;
      out_q <= '0;
    end else begin
      acc_q <= acc_d;
      out_q <= out_d;
    end
  end

  assign out_o = out_q;

endmodule

// File: rtl/complex_accumulator_array_parallel.sv
// complex_accumulator_array_parallel
//   64-lane (4x4x4) complex accumulator array. Sums per-lane addends over a
//   start/stop-delimited burst and presents the sums with a one-cycle
//   output_valid pulse in the cycle after stop.
//   Ports:
//   - clk, reset_n : clock, synchronous active-low reset
//   - bus (slave)  : in, start, stop -> out, output_valid
//   Build option: CPLX_ACC_SATURATE_EN selects clamping adds in every lane
//   (default build wraps modulo 2^DATA_WIDTH).
module complex_accumulator_array_parallel
  import complex_accumulator_array_parallel_pkg::*;
#(
  parameter int DATA_WIDTH = CPLX_DATA_WIDTH
) (
  input logic                             clk,
  input logic                             reset_n,
  complex_accumulator_array_parallel_if.slave bus
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_ACC  = 1'b1;

  logic [0:0] state_q, state_d;
  logic       valid_q, valid_d;

  logic load, add, finish, single;
  lane_array_t lane_out;

  // Shared lane strobes. start&stop wins over everything (single burst),
  // and start alone always (re)loads, discarding any partial sum.
  always_comb begin
    single = bus.start && bus.stop;
    load   = bus.start && !bus.stop;
    add    = (state_q == ST_ACC) && !bus.start && !bus.stop;
    finish = (state_q == ST_ACC) && !bus.start && bus.stop;

    state_d = state_q;
    if (single || finish) begin
      state_d = ST_IDLE;
    end else if (load) begin
      state_d = ST_ACC;
    end

    valid_d = single || finish;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
    end
  end

  genvar gi, gj, gk;
  generate
    for (gi = 0; gi < DIM_I; gi++) begin : g_i
      for (gj = 0; gj < DIM_J; gj++) begin : g_j
        for (gk = 0; gk < DIM_K; gk++) begin : g_k
          complex_accumulator #(
            .DATA_WIDTH(DATA_WIDTH)
          ) u_lane (
            .clk      (clk),
            .reset_n  (reset_n),
            .in_i     (bus.in[gi][gj][gk]),
            .load_i   (load),
            .add_i    (add),
            .finish_i (finish),
            .single_i (single),
            .out_o    (lane_out[gi][gj][gk])
          );
        end
      end
    end
  endgenerate

  assign bus.out          = lane_out;
  assign bus.output_valid = valid_q;

endmodule

// File: tb/tb_complex_accumulator_array_parallel.sv
module tb_complex_accumulator_array_parallel;
  import complex_accumulator_array_parallel_pkg::*;

  logic clk;
  logic reset_n;
  int   total;
  int   bad;
  lane_array_t exp_out;

  complex_accumulator_array_parallel_if bus_if ();

  complex_accumulator_array_parallel dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs and outputs are both handled 1 time unit
  // after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_all(input logic start, input logic stop,
                           input logic [31:0] re, input logic [31:0] im);
    bus_if.start = start;
    bus_if.stop  = stop;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        for (int k = 0; k < 4; k++) begin
          bus_if.in[i][j][k].re = re;
          bus_if.in[i][j][k].im = im;
        end
  endtask

  task automatic expect_all(input logic [31:0] re, input logic [31:0] im);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        for (int k = 0; k < 4; k++) begin
          exp_out[i][j][k].re = re;
          exp_out[i][j][k].im = im;
        end
  endtask

  task automatic check_lanes(input string tag);
    int mism;
    mism = 0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        for (int k = 0; k < 4; k++)
          if (bus_if.out[i][j][k] !== exp_out[i][j][k]) begin
            if (mism == 0)
              check_val($sformatf("%s lane%0d", tag, i*16+j*4+k),
                        bus_if.out[i][j][k], exp_out[i][j][k]);
            mism++;
          end
    // One comparison per lane-set; a mismatch above already counted.
    if (mism == 0) check_val({tag, " lanes"}, bus_if.out[0][0][0], exp_out[0][0][0]);
    $display("txn %s: valid=%0b lane0=(%0d,%0d) lane_mismatches=%0d", tag,
             bus_if.output_valid, $signed(bus_if.out[0][0][0].re),
             $signed(bus_if.out[0][0][0].im), mism);
  endtask

  task automatic check_valid(input string tag, input logic exp);
    check_val({tag, " valid"}, {63'd0, bus_if.output_valid}, {63'd0, exp});
  endtask

  initial begin
    total = 0;
    bad   = 0;

    // Reset held two cycles with start asserted.
    reset_n = 1'b0;
    drive_all(1'b1, 1'b0, 32'd7, 32'd7);
    step();
    step();
    expect_all(32'd0, 32'd0);
    check_valid("reset", 1'b0);
    check_lanes("reset");
    reset_n = 1'b1;
    drive_all(1'b0, 1'b0, 32'd7, 32'd7);
    for (int n = 0; n < 3; n++) begin
      step();
      check_valid("idle", 1'b0);
    end

    // 3-cycle burst: (1,2)+(3,-4)+(5,6) = (9,4).
    drive_all(1'b1, 1'b0, 32'd1, 32'd2);
    step();
    check_valid("b3 c0", 1'b0);
    drive_all(1'b0, 1'b0, 32'd3, -32'sd4);
    step();
    check_valid("b3 c1", 1'b0);
    drive_all(1'b0, 1'b1, 32'd5, 32'd6);
    step();
    check_valid("b3 res", 1'b1);
    expect_all(32'd9, 32'd4);
    check_lanes("b3 res");
    drive_all(1'b0, 1'b0, 32'd100, 32'd100);
    step();
    check_valid("b3 after", 1'b0);
    check_lanes("b3 hold");

    // Single-cycle burst with distinct per-lane values.
    bus_if.start = 1'b1;
    bus_if.stop  = 1'b1;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        for (int k = 0; k < 4; k++) begin
          bus_if.in[i][j][k].re = i*16 + j*4 + k;
          bus_if.in[i][j][k].im = -32'sd1;
          exp_out[i][j][k].re   = i*16 + j*4 + k;
          exp_out[i][j][k].im   = -32'sd1;
        end
    step();
    check_valid("single", 1'b1);
    check_lanes("single");
    drive_all(1'b0, 1'b0, 32'd0, 32'd0);
    step();
    check_valid("single after", 1'b0);

    // Restart: (10,10) discarded, (1,1)+(2,2) = (3,3).
    drive_all(1'b1, 1'b0, 32'd10, 32'd10);
    step();
    check_valid("rs c0", 1'b0);
    drive_all(1'b1, 1'b0, 32'd1, 32'd1);
    step();
    check_valid("rs c1", 1'b0);
    drive_all(1'b0, 1'b1, 32'd2, 32'd2);
    step();
    check_valid("rs res", 1'b1);
    expect_all(32'd3, 32'd3);
    check_lanes("restart");
    drive_all(1'b0, 1'b0, 32'd0, 32'd0);
    step();
    check_valid("rs after", 1'b0);

    // start&stop while a burst is open: partial sum discarded, out = in.
    drive_all(1'b1, 1'b0, 32'd100, 32'd0);
    step();
    drive_all(1'b1, 1'b1, 32'd7, -32'sd7);
    step();
    check_valid("ss in acc", 1'b1);
    expect_all(32'd7, -32'sd7);
    check_lanes("ss in acc");

    // Overflow of the real component.
    drive_all(1'b1, 1'b0, 32'h7FFF_FFFF, 32'd0);
    step();
    drive_all(1'b0, 1'b1, 32'd1, 32'd0);
    step();
    check_valid("ovf", 1'b1);
`ifdef CPLX_ACC_SATURATE_EN
    expect_all(32'h7FFF_FFFF, 32'd0);
`else
    expect_all(32'h8000_0000, 32'd0);
`endif
    check_lanes("overflow");

    // Back-to-back: 5-addend burst (k,-k) k=1..5 -> (15,-15), stop on
    // cycle 4, next burst starts on cycle 5: (10,-1)+(20,-2) = (30,-3).
    for (int n = 1; n <= 5; n++) begin
      drive_all(n == 1, n == 5, n, -n);
      step();
      check_valid($sformatf("bb a%0d", n), n == 5);
    end
    expect_all(32'd15, -32'sd15);
    check_lanes("bb a");
    drive_all(1'b1, 1'b0, 32'd10, -32'sd1);
    step();
    check_valid("bb b0", 1'b0);
    drive_all(1'b0, 1'b1, 32'd20, -32'sd2);
    step();
    check_valid("bb b1", 1'b1);
    expect_all(32'd30, -32'sd3);
    check_lanes("bb b");

    // Reset mid-burst: no result, later stop in IDLE is ignored.
    drive_all(1'b1, 1'b0, 32'd5, 32'd5);
    step();
    reset_n = 1'b0;
    drive_all(1'b0, 1'b0, 32'd5, 32'd5);
    step();
    check_valid("mid rst", 1'b0);
    reset_n = 1'b1;
    drive_all(1'b0, 1'b1, 32'd5, 32'd5);
    step();
    check_valid("stop idle", 1'b0);
    expect_all(32'd0, 32'd0);
    check_lanes("mid rst");
    drive_all(1'b0, 1'b0, 32'd0, 32'd0);
    step();
    check_valid("end", 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
